uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART receive side of the serial link, the counterpart to the team's uart_transmitter.
- Oversamples the asynchronous RsRx line at 16x baud on the same sampling clock.
- Validates start and stop bits and assembles 8N1 frames, LSB first.
- Presents each byte to downstream logic through a one-entry holding register with a valid/ready handshake.
- Sits between the board RX pin and the command/data consumer.

Parameters:
OVERSAMPLE, 16, sampling clocks per bit; fixed, counters sized for it.
DATA_BITS, 8, payload bits per frame.

Ports:
uart_samplig_clk  input  1  sampling clock, 16x baud; the block's only clock.
reset  input  1  asynchronous, active-high reset.
RsRx  input  1  raw serial line; idle high; asynchronous to uart_samplig_clk.
valid  output  1  holding register contains an unconsumed byte.
ready  input  1  consumer accepts the byte; transfer occurs when valid && ready.
data_received  output  8  received byte; stable while valid=1.
framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.

Behaviour:
- Interface (decided): single clock uart_samplig_clk; reset is asynchronous and active-high. All flops clear on reset assertion.
- Reset values:
  - valid=0, data_received=0, framing_error=0, overrun=0.
  - Both synchronizer flops = 1.
  - State=IDLE; sample_cnt=0, bit_cnt=0, shift register=0.
- Synchronizer: RsRx passes through 2 flops to produce rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START with sample_cnt=0.
- START: sample_cnt increments every clock. At sample_cnt==7 (mid start bit):
  - rx_s==0 -> DATA, with sample_cnt=0 and bit_cnt=0.
  - rx_s==1 -> IDLE (glitch rejected, nothing reported).
- DATA:
  - At sample_cnt==15, shift rx_s into the MSB of the shift register (right shift), so the LSB arrives first.
  - sample_cnt wraps to 0 and bit_cnt increments.
  - After the sample with bit_cnt==7 -> STOP.
- STOP: at sample_cnt==15:
  - rx_s==1 -> frame complete; deliver to the holding register (rules below); -> IDLE.
  - rx_s==0 -> framing_error pulses for exactly 1 cycle; byte discarded; -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line must never be decoded as repeated 0x00 frames.
- Timing, with rx_s first seen low in IDLE at cycle N:
  - Start sampled at N+8.
  - Data bit k sampled at N+8+16(k+1).
  - Stop sampled at N+152.
  - valid rises at N+153.
- Holding register and handshake:
  - valid falls the cycle after valid && ready.
  - Delivery with valid=0: load data_received and set valid=1.
  - Delivery with valid=1 and ready=1 in the same cycle: load the new byte; valid stays 1. Not an overrun.
  - Delivery with valid=1 and ready=0: new byte dropped; data_received unchanged; overrun set. overrun is sticky until reset.
- Receiver FSM never stalls on ready. The line is sampled continuously.
- Reset mid-frame: immediately IDLE with all outputs cleared. The partial frame is lost. If the line is low when reset releases, it is treated as a start edge.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (3-bit).
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15, DATA_BITS=8.
  - Shared with uart_transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1. Reusable for other async inputs.
- Remainder (FSM, counters, shift register, holding register) stays in uart_receiver.

Test Plan:
- Send 0x55 (ready=1) -> valid pulses 1 cycle, data_received=0x55, at N+153; framing_error=0, overrun=0.
- Back-to-back frames 0xA3 then 0x0F, stop bit only 16 clocks, ready=1 -> two valid pulses with 0xA3 then 0x0F, 160 cycles apart.
- RsRx low for 4 clocks then high -> FSM returns to IDLE at the mid-start check; valid never asserts.
- Frame 0x3C with stop bit driven low, then line held low 400 clocks, then high -> single 1-cycle framing_error pulse; valid stays 0; no further frames during the low period.
- ready=0, send 0x11 then 0x22 -> valid=1, data_received=0x11, overrun=1 after the second stop bit. Then ready=1 for one cycle -> valid=0, overrun still 1.
- Assert reset during data bit 4 of 0xFF, release while the line is idle, then send 0x81 -> only 0x81 delivered; no spurious valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and receiver state encoding.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int MID_SAMPLE   = 7;
  localparam int LAST_SAMPLE  = 15;
  localparam int DATA_BITS    = 8;

  localparam int SAMPLE_CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W    = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync
);

  logic meta;

  // Both stages reset high so an idle line is not mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      meta   <= d_async;
      d_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled, with a one-entry valid/ready holding register.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for rx_s to go low
//   ST_START | counting to mid start bit to confirm it is not a glitch
//   ST_DATA  | sampling 8 data bits, LSB first, one per 16 clocks
//   ST_STOP  | sampling the stop bit; high delivers, low flags framing error
//   ST_BREAK | line held low after a bad stop bit; wait for it to return high
module uart_receiver
  import uart_pkg::*;
(
  input  logic                 uart_samplig_clk,
  input  logic                 reset,
  input  logic                 RsRx,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 framing_error,
  output logic                 overrun
);

  logic                    rx_s;
  rx_state_t               state;
  rx_state_t               state_nxt;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [DATA_BITS-1:0]    shift_reg;

  logic cnt_clr;
  logic bit_sample;
  logic frame_done;
  logic stop_bad;
  logic at_mid;
  logic at_last;

  uart_rx_sync u_sync (
    .clk     (uart_samplig_clk),
    .rst     (reset),
    .d_async (RsRx),
    .d_sync  (rx_s)
  );

  assign at_mid  = (sample_cnt == SAMPLE_CNT_W'(MID_SAMPLE));
  assign at_last = (sample_cnt == SAMPLE_CNT_W'(LAST_SAMPLE));

  // State register.
  always_ff @(posedge uart_samplig_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    bit_sample = 1'b0;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (at_mid) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_last) begin
          bit_sample = 1'b1;
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_last) begin
          if (rx_s) begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Oversample counter, bit counter and LSB-first shift register.
  always_ff @(posedge uart_samplig_clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      if (cnt_clr)
        sample_cnt <= '0;
      else if (state == ST_START || state == ST_DATA || state == ST_STOP)
        sample_cnt <= sample_cnt + 1'b1;
      else
        sample_cnt <= '0;

      if (cnt_clr)
        bit_cnt <= '0;
      else if (bit_sample)
        bit_cnt <= bit_cnt + 1'b1;

      if (bit_sample)
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Holding register: the receiver never stalls, so a full, unconsumed
  // register drops the new byte and latches overrun until reset.
  always_ff @(posedge uart_samplig_clk or posedge reset) begin
    if (reset) begin
      valid         <= 1'b0;
      data_received <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= stop_bad;
      if (frame_done) begin
        if (!valid || ready) begin
          data_received <= shift_reg;
          valid         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames.
module tb_uart_receiver;

  localparam int LAT   = 155;  // RsRx falls in cycle s -> valid/framing_error seen in cycle s+155
  localparam int FRAME = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       RsRx;
  logic       ready;
  logic       valid;
  logic [7:0] data_received;
  logic       framing_error;
  logic       overrun;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;

  ev_t  v_log[$];
  int   fe_log[$];
  int   valid_hi = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver dut (
    .uart_samplig_clk (clk),
    .reset            (reset),
    .RsRx             (RsRx),
    .valid            (valid),
    .ready            (ready),
    .data_received    (data_received),
    .framing_error    (framing_error),
    .overrun          (overrun)
  );

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid && !prev_valid) v_log.push_back('{cyc, data_received});
    if (valid) valid_hi++;
    if (framing_error) fe_log.push_back(cyc);
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RsRx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    v_log.delete();
    fe_log.delete();
    valid_hi = 0;
  endtask

  // Drives one full 160-clock frame; returns the cycle the start bit began.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, output int s);
    RsRx = 1'b0;
    s = cyc;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (16) tick();
    end
    RsRx = stop_val;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RsRx  = 1'b1;
    ready = 1'b1;
    repeat (3) tick();
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", valid); n_err++; end
    n_cmp++; if (data_received !== 8'h00) begin $display("FAIL reset_data: got %02h expected 00", data_received); n_err++; end
    n_cmp++; if (framing_error !== 1'b0) begin $display("FAIL reset_fe: got %b expected 0", framing_error); n_err++; end
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun: got %b expected 0", overrun); n_err++; end
    reset = 1'b0;
    clear_logs();
    idle(20);
    n_cmp++; if (v_log.size() !== 0) begin $display("FAIL reset_idle_valid: got %0d pulses expected 0", v_log.size()); n_err++; end
  endtask

  task automatic test_single();
    int s;
    clear_logs();
    ready = 1'b1;
    send_frame(8'h55, 1'b1, s);
    idle(20);
    n_cmp++;
    if (v_log.size() !== 1) begin
      $display("FAIL single_count: got %0d pulses expected 1", v_log.size()); n_err++;
    end else begin
      n_cmp++; if (v_log[0].c !== s + LAT) begin $display("FAIL single_time: got %0d expected %0d", v_log[0].c, s + LAT); n_err++; end
      n_cmp++; if (v_log[0].d !== 8'h55) begin $display("FAIL single_data: got %02h expected 55", v_log[0].d); n_err++; end
    end
    n_cmp++; if (valid_hi !== 1) begin $display("FAIL single_width: got %0d cycles expected 1", valid_hi); n_err++; end
    n_cmp++; if (fe_log.size() !== 0) begin $display("FAIL single_fe: got %0d pulses expected 0", fe_log.size()); n_err++; end
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL single_overrun: got %b expected 0", overrun); n_err++; end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_logs();
    ready = 1'b1;
    send_frame(8'hA3, 1'b1, s1);
    send_frame(8'h0F, 1'b1, s2);
    idle(20);
    n_cmp++;
    if (v_log.size() !== 2) begin
      $display("FAIL b2b_count: got %0d pulses expected 2", v_log.size()); n_err++;
    end else begin
      n_cmp++; if (v_log[0].d !== 8'hA3) begin $display("FAIL b2b_data0: got %02h expected a3", v_log[0].d); n_err++; end
      n_cmp++; if (v_log[1].d !== 8'h0F) begin $display("FAIL b2b_data1: got %02h expected 0f", v_log[1].d); n_err++; end
      n_cmp++; if (v_log[0].c !== s1 + LAT) begin $display("FAIL b2b_time0: got %0d expected %0d", v_log[0].c, s1 + LAT); n_err++; end
      n_cmp++; if (v_log[1].c - v_log[0].c !== FRAME) begin $display("FAIL b2b_spacing: got %0d expected %0d", v_log[1].c - v_log[0].c, FRAME); n_err++; end
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    RsRx = 1'b0;
    repeat (4) tick();
    idle(200);
    n_cmp++; if (v_log.size() !== 0) begin $display("FAIL glitch_valid: got %0d pulses expected 0", v_log.size()); n_err++; end
    n_cmp++; if (fe_log.size() !== 0) begin $display("FAIL glitch_fe: got %0d pulses expected 0", fe_log.size()); n_err++; end
  endtask

  task automatic test_framing();
    int s;
    clear_logs();
    send_frame(8'h3C, 1'b0, s);
    repeat (400) tick();
    idle(30);
    n_cmp++;
    if (fe_log.size() !== 1) begin
      $display("FAIL fe_count: got %0d pulses expected 1", fe_log.size()); n_err++;
    end else begin
      n_cmp++; if (fe_log[0] !== s + LAT) begin $display("FAIL fe_time: got %0d expected %0d", fe_log[0], s + LAT); n_err++; end
    end
    n_cmp++; if (v_log.size() !== 0) begin $display("FAIL fe_valid: got %0d pulses expected 0", v_log.size()); n_err++; end
  endtask

  task automatic test_overrun();
    int s1, s2;
    clear_logs();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, s1);
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL ovr_early: got %b expected 0", overrun); n_err++; end
    send_frame(8'h22, 1'b1, s2);
    idle(10);
    n_cmp++; if (valid !== 1'b1) begin $display("FAIL ovr_valid: got %b expected 1", valid); n_err++; end
    n_cmp++; if (data_received !== 8'h11) begin $display("FAIL ovr_data: got %02h expected 11", data_received); n_err++; end
    n_cmp++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag: got %b expected 1", overrun); n_err++; end
    n_cmp++; if (v_log.size() !== 1) begin $display("FAIL ovr_pulses: got %0d expected 1", v_log.size()); n_err++; end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL ovr_consume: got %b expected 0", valid); n_err++; end
    idle(5);
    n_cmp++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky: got %b expected 1", overrun); n_err++; end
    ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int s;
    clear_logs();
    ready = 1'b1;
    RsRx  = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 5; i++) begin
      RsRx = 1'b1;
      repeat ((i == 4) ? 8 : 16) tick();
    end
    reset = 1'b1;
    RsRx  = 1'b1;
    repeat (3) tick();
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL mid_reset_overrun: got %b expected 0", overrun); n_err++; end
    reset = 1'b0;
    idle(40);
    send_frame(8'h81, 1'b1, s);
    idle(20);
    n_cmp++;
    if (v_log.size() !== 1) begin
      $display("FAIL mid_reset_count: got %0d pulses expected 1", v_log.size()); n_err++;
    end else begin
      n_cmp++; if (v_log[0].d !== 8'h81) begin $display("FAIL mid_reset_data: got %02h expected 81", v_log[0].d); n_err++; end
      n_cmp++; if (v_log[0].c !== s + LAT) begin $display("FAIL mid_reset_time: got %0d expected %0d", v_log[0].c, s + LAT); n_err++; end
    end
  endtask

  // Random bytes with random gaps and occasional bad stop bits; the model
  // predicts one delivery per good frame and one error pulse per bad one.
  task automatic test_random();
    ev_t exp_v[$];
    int  exp_fe[$];
    int  s;
    logic [7:0] b;
    logic bad;
    clear_logs();
    ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      idle($urandom_range(0, 30));
      send_frame(b, !bad, s);
      if (bad) begin
        exp_fe.push_back(s + LAT);
        repeat ($urandom_range(0, 50)) tick();
        idle(4);
      end else begin
        exp_v.push_back('{s + LAT, b});
      end
    end
    idle(20);
    n_cmp++;
    if (v_log.size() !== exp_v.size()) begin
      $display("FAIL rand_count: got %0d pulses expected %0d", v_log.size(), exp_v.size()); n_err++;
    end else begin
      foreach (exp_v[i]) begin
        n_cmp++;
        if (v_log[i].d !== exp_v[i].d || v_log[i].c !== exp_v[i].c)
          begin $display("FAIL rand_frame%0d: got %02h@%0d expected %02h@%0d", i, v_log[i].d, v_log[i].c, exp_v[i].d, exp_v[i].c); n_err++; end
      end
    end
    n_cmp++;
    if (fe_log.size() !== exp_fe.size()) begin
      $display("FAIL rand_fe_count: got %0d expected %0d", fe_log.size(), exp_fe.size()); n_err++;
    end else begin
      foreach (exp_fe[i]) begin
        n_cmp++;
        if (fe_log[i] !== exp_fe[i]) begin $display("FAIL rand_fe%0d: got %0d expected %0d", i, fe_log[i], exp_fe[i]); n_err++; end
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL rand_overrun: got %b expected 0", overrun); n_err++; end
  endtask

  initial begin
    reset = 1'b1;
    RsRx  = 1'b1;
    ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
